pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall masks, one-cycle flush
// pulse with redirect target, stall watchdog and stalled-cycle statistics.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE  = 32'h0000_000e,
  parameter int unsigned WDT_LIMIT  = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [4:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_timeout_o,
  output logic [31:0] stall_cycles_o
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [9:0] WDT_MAX = 10'(WDT_LIMIT);

  state_e      state_q, state_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [9:0]  wdt_cnt_q, wdt_cnt_d;
  logic        stall_timeout_q, stall_timeout_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic        stalled;

  // Freeze the whole pipe while an exception is pending; the flush cycle and
  // reset release every stage so the cleared registers can load.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    stall_o = 5'b00000;
    if (!rst && state_q == RUN) begin
      if (excepttype_i != 32'd0)  stall_o = 5'b11111;
      else if (stallreq_from_mem) stall_o = 5'b01111;
      else if (stallreq_from_ex)  stall_o = 5'b00111;
      else if (stallreq_from_id)  stall_o = 5'b00011;
      else if (stallreq_from_if)  stall_o = 5'b00001;
    end
  end

  assign stalled = |stall_o;

  always_comb begin
    state_d  = state_q;
    flush_d  = 1'b0;
    new_pc_d = 32'd0;
    case (state_q)
      RUN: begin
        if (excepttype_i != 32'd0) begin
          state_d  = FLUSH;
          flush_d  = 1'b1;
          new_pc_d = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase

    if (!stalled)                 wdt_cnt_d = 10'd0;
    else if (wdt_cnt_q >= WDT_MAX) wdt_cnt_d = wdt_cnt_q;
    else                          wdt_cnt_d = wdt_cnt_q + 10'd1;

    stall_timeout_d = stall_timeout_q | (stalled && wdt_cnt_d == WDT_MAX);
    stall_cycles_d  = stalled ? stall_cycles_q + 32'd1 : stall_cycles_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q         <= RUN;
      flush_q         <= 1'b0;
      new_pc_q        <= 32'd0;
      wdt_cnt_q       <= 10'd0;
      stall_timeout_q <= 1'b0;
      stall_cycles_q  <= 32'd0;
    end else begin
      state_q         <= state_d;
      flush_q         <= flush_d;
      new_pc_q        <= new_pc_d;
      wdt_cnt_q       <= wdt_cnt_d;
      stall_timeout_q <= stall_timeout_d;
      stall_cycles_q  <= stall_cycles_d;
    end
  end

  assign flush_o         = flush_q;
  assign new_pc_o        = new_pc_q;
  assign stall_timeout_o = stall_timeout_q;
  assign stall_cycles_o  = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboarded directed test of pipe_ctrl with a short watchdog limit.
module tb_pipe_ctrl;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_from_if = 1'b0;
  logic        stallreq_from_id = 1'b0;
  logic        stallreq_from_ex = 1'b0;
  logic        stallreq_from_mem = 1'b0;
  logic [31:0] excepttype_i = 32'd0;
  logic [31:0] cp0_epc_i = 32'd0;
  logic [4:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        stall_timeout_o;
  logic [31:0] stall_cycles_o;

  pipe_ctrl #(
    .EXC_VECTOR(32'h0000_0020),
    .ERET_CODE (32'h0000_000e),
    .WDT_LIMIT (LIMIT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_if (stallreq_from_if),
    .stallreq_from_id (stallreq_from_id),
    .stallreq_from_ex (stallreq_from_ex),
    .stallreq_from_mem(stallreq_from_mem),
    .excepttype_i     (excepttype_i),
    .cp0_epc_i        (cp0_epc_i),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .new_pc_o         (new_pc_o),
    .stall_timeout_o  (stall_timeout_o),
    .stall_cycles_o   (stall_cycles_o)
  );

  always #5 clk = ~clk;

  // req bits are {if, id, ex, mem}; frc preloads the cycle counter to all ones.
  typedef struct {
    logic        rst;
    logic        frc;
    logic [3:0]  req;
    logic [31:0] exc;
    logic [31:0] epc;
    logic [4:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        to;
  } vec_t;

  typedef struct {
    int          idx;
    logic [4:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        to;
    logic [31:0] cycles;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   drive_done = 1'b0;

  function automatic vec_t mk(input logic r, input logic f, input logic [3:0] req,
                              input logic [31:0] exc, input logic [31:0] epc,
                              input logic [4:0] st, input logic fl,
                              input logic [31:0] pc, input logic to);
    vec_t v;
    v.rst = r; v.frc = f; v.req = req; v.exc = exc; v.epc = epc;
    v.stall = st; v.flush = fl; v.pc = pc; v.to = to;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, req);
    end
  endtask

  initial begin
    //            rst frc req     exc           epc            stall     fl pc            to
    vecs.push_back(mk(1, 0, 4'b0001, 32'h0, 32'h0,         5'b00000, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0, 32'h0,         5'b00000, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b1111, 32'h0, 32'h0,         5'b01111, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b1110, 32'h0, 32'h0,         5'b00111, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b1100, 32'h0, 32'h0,         5'b00011, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0, 32'h0,         5'b00000, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b1000, 32'h0, 32'h0,         5'b00001, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0, 32'h0,         5'b00000, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b0010, 32'h8, 32'h0,         5'b11111, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b0010, 32'h8, 32'h0,         5'b00000, 1, 32'h20,        0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0, 32'h0,         5'b00000, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'he, 32'h8000_1234, 5'b11111, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0, 32'hdead_beef, 5'b00000, 1, 32'h8000_1234, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0, 32'h0,         5'b00000, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h8, 32'h0,         5'b11111, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h8, 32'h0,         5'b00000, 1, 32'h20,        0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h8, 32'h0,         5'b11111, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0, 32'h0,         5'b00000, 1, 32'h20,        0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0, 32'h0,         5'b00000, 0, 32'h0,         0));
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++)
        vecs.push_back(mk(0, 0, 4'b0001, 32'h0, 32'h0,     5'b01111, 0, 32'h0,         0));
      vecs.push_back(mk(0, 0, 4'b0000, 32'h0, 32'h0,       5'b00000, 0, 32'h0,         0));
    end
    for (int j = 0; j < 4; j++)
      vecs.push_back(mk(0, 0, 4'b0001, 32'h0, 32'h0,       5'b01111, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0, 32'h0,         5'b00000, 0, 32'h0,         1));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0, 32'h0,         5'b00000, 0, 32'h0,         1));
    vecs.push_back(mk(0, 1, 4'b0001, 32'h0, 32'h0,         5'b01111, 0, 32'h0,         1));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0, 32'h0,         5'b00000, 0, 32'h0,         1));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h8, 32'h0,         5'b11111, 0, 32'h0,         1));
    vecs.push_back(mk(1, 0, 4'b0000, 32'h8, 32'h0,         5'b00000, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0, 32'h0,         5'b00000, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0, 32'h0,         5'b00000, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b1000, 32'h0, 32'h0,         5'b00001, 0, 32'h0,         0));
    vecs.push_back(mk(0, 0, 4'b0000, 32'h0, 32'h0,         5'b00000, 0, 32'h0,         0));
  end

  // Driver: applies one vector 1 ns after each rising edge and queues the
  // outputs expected for the rest of that cycle.
  initial begin : driver
    logic [31:0] cyc;
    exp_t        e;
    cyc = 32'd0;
    #0;
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst               = vecs[i].rst;
      stallreq_from_if  = vecs[i].req[3];
      stallreq_from_id  = vecs[i].req[2];
      stallreq_from_ex  = vecs[i].req[1];
      stallreq_from_mem = vecs[i].req[0];
      excepttype_i      = vecs[i].exc;
      cp0_epc_i         = vecs[i].epc;
      if (vecs[i].frc) begin
        force dut.stall_cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles_q;
        cyc = 32'hFFFF_FFFF;
      end
      if (vecs[i].rst) cyc = 32'd0;
      e.idx = i; e.stall = vecs[i].stall; e.flush = vecs[i].flush;
      e.pc = vecs[i].pc; e.to = vecs[i].to; e.cycles = cyc;
      exp_q.push_back(e);
      if (!vecs[i].rst && vecs[i].stall != 5'b00000) cyc = cyc + 32'd1;
    end
    drive_done = 1'b1;
  end

  // Monitor: outputs are valid every cycle; compare mid-cycle on the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall_o",         e.idx, 32'(stall_o),         32'(e.stall));
        check("flush_o",         e.idx, 32'(flush_o),         32'(e.flush));
        check("new_pc_o",        e.idx, new_pc_o,             e.pc);
        check("stall_timeout_o", e.idx, 32'(stall_timeout_o), 32'(e.to));
        check("stall_cycles_o",  e.idx, stall_cycles_o,       e.cycles);
      end
    end
  end

  initial begin : control
    int budget;
    budget = 0;
    while (!drive_done && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (!drive_done || exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: driver_done=%0d pending=%0d expected done=1 pending=0",
               drive_done, exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
